// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl
//   RV64 immediate decode stage with a two-entry (main + skid) output buffer.
//   Each accepted instruction is decoded combinationally and stored together
//   with its decode result, so every output is driven from registers only.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     upstream instruction valid
//   in_ready     registered: stage can accept this cycle (state != TWO)
//   in_instr     32-bit instruction word
//   flush        synchronous discard of all held entries
//   out_valid    decoded entry presented (state != EMPTY)
//   out_ready    downstream accepts the presented entry
//   out_instr    instruction of the presented entry
//   out_imm      XLEN-bit immediate of the presented entry
//   out_fmt      0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM
//   out_illegal  opcode not recognised
module imm_decode_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_ZIMM  = 3'd7;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    // Signed views of each immediate field; the width cast sign-extends them.
    function automatic entry_t decode(input logic [31:0] instr);
        entry_t             e;
        logic signed [11:0] imm_i;
        logic signed [11:0] imm_s;
        logic signed [12:0] imm_b;
        logic signed [31:0] imm_u;
        logic signed [20:0] imm_j;
        imm_i = instr[31:20];
        imm_s = {instr[31:25], instr[11:7]};
        imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u = {instr[31:12], 12'b0};
        imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        e.instr   = instr;
        e.imm     = '0;
        e.fmt     = FMT_NONE;
        e.illegal = 1'b0;
        case (instr[6:0])
            7'b0000011, 7'b1100111, 7'b0001111: begin
                e.fmt = FMT_I;
                e.imm = XLEN'(imm_i);
            end
            // funct3 001/101 are the shift-immediate forms
            7'b0010011: begin
                if (instr[13:12] == 2'b01) begin
                    e.fmt = FMT_SHAMT;
                    e.imm = XLEN'(instr[25:20]);
                end else begin
                    e.fmt = FMT_I;
                    e.imm = XLEN'(imm_i);
                end
            end
            7'b0011011: begin
                if (instr[13:12] == 2'b01) begin
                    e.fmt = FMT_SHAMT;
                    e.imm = XLEN'(instr[24:20]);
                end else begin
                    e.fmt = FMT_I;
                    e.imm = XLEN'(imm_i);
                end
            end
            7'b0100011: begin
                e.fmt = FMT_S;
                e.imm = XLEN'(imm_s);
            end
            7'b1100011: begin
                e.fmt = FMT_B;
                e.imm = XLEN'(imm_b);
            end
            7'b0110111, 7'b0010111: begin
                e.fmt = FMT_U;
                e.imm = XLEN'(imm_u);
            end
            7'b1101111: begin
                e.fmt = FMT_J;
                e.imm = XLEN'(imm_j);
            end
            // CSR immediate forms carry a 5-bit zimm in the rs1 field
            7'b1110011: begin
                if (instr[14]) begin
                    e.fmt = FMT_ZIMM;
                    e.imm = XLEN'(instr[19:15]);
                end else begin
                    e.fmt = FMT_I;
                    e.imm = XLEN'(imm_i);
                end
            end
            7'b0110011, 7'b0111011: begin
                e.fmt = FMT_NONE;
            end
            default: begin
                e.illegal = 1'b1;
            end
        endcase
        return e;
    endfunction

    state_t state;
    state_t state_nxt;
    logic   in_ready_r;
    logic   accept;
    logic   pop;
    logic   ld_main;
    logic   ld_main_skid;
    logic   ld_skid;
    entry_t dec_p0;
    entry_t main_p1;
    entry_t skid_p1;

    // ---- p0: decode of the incoming instruction ----
    assign dec_p0 = decode(in_instr);

    assign in_ready  = in_ready_r;
    assign out_valid = (state != S_EMPTY);
    assign accept    = in_valid & in_ready_r;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_nxt    = state;
        ld_main      = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    state_nxt = S_ONE;
                    ld_main   = 1'b1;
                end
            end
            S_ONE: begin
                if (accept && !pop) begin
                    state_nxt = S_TWO;
                    ld_skid   = 1'b1;
                end else if (pop && !accept) begin
                    state_nxt = S_EMPTY;
                end else if (accept && pop) begin
                    ld_main = 1'b1;
                end
            end
            S_TWO: begin
                if (pop) begin
                    state_nxt    = S_ONE;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
        if (flush) begin
            state_nxt    = S_EMPTY;
            ld_main      = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    // ---- p1: occupancy control and registered ready ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_EMPTY;
            in_ready_r <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_ready_r <= (state_nxt != S_TWO);
        end
    end

    // Entry storage is not reset; outputs are masked by occupancy instead.
    always_ff @(posedge clk) begin
        if (ld_main) begin
            main_p1 <= dec_p0;
        end else if (ld_main_skid) begin
            main_p1 <= skid_p1;
        end
        if (ld_skid) begin
            skid_p1 <= dec_p0;
        end
    end

    assign out_instr   = out_valid ? main_p1.instr   : '0;
    assign out_imm     = out_valid ? main_p1.imm     : '0;
    assign out_fmt     = out_valid ? main_p1.fmt     : FMT_NONE;
    assign out_illegal = out_valid ? main_p1.illegal : 1'b0;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Scoreboard bench for imm_decode_ctrl: the driver pushes the reference
// decode of every accepted instruction, a negedge monitor pops and compares.
module tb_imm_decode_ctrl;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_instr = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    imm_decode_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   armed = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the encoding tables.
    function automatic exp_t model(input logic [31:0] ins);
        exp_t       e;
        logic [2:0] f3;
        f3 = ins[14:12];
        e.instr = ins;
        e.illegal = 1'b0;
        e.imm = 64'd0;
        e.fmt = 3'd0;
        case (ins[6:0])
            7'h03, 7'h67, 7'h0F: e.fmt = 3'd1;
            7'h13, 7'h1B:        e.fmt = (f3 == 3'd1 || f3 == 3'd5) ? 3'd6 : 3'd1;
            7'h23:               e.fmt = 3'd2;
            7'h63:               e.fmt = 3'd3;
            7'h37, 7'h17:        e.fmt = 3'd4;
            7'h6F:               e.fmt = 3'd5;
            7'h73:               e.fmt = f3[2] ? 3'd7 : 3'd1;
            7'h33, 7'h3B:        e.fmt = 3'd0;
            default:             e.illegal = 1'b1;
        endcase
        case (e.fmt)
            3'd1: e.imm = longint'($signed(ins[31:20]));
            3'd2: e.imm = longint'($signed({ins[31:25], ins[11:7]}));
            3'd3: e.imm = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'd4: e.imm = longint'($signed({ins[31:12], 12'h000}));
            3'd5: e.imm = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            3'd6: e.imm = (ins[6:0] == 7'h13) ? {58'd0, ins[25:20]} : {59'd0, ins[24:20]};
            3'd7: e.imm = {59'd0, ins[19:15]};
            default: e.imm = 64'd0;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [13] = '{7'h03, 7'h67, 7'h0F, 7'h13, 7'h1B, 7'h23, 7'h63,
                                  7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h3B};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 12)];
        return w;
    endfunction

    // Monitor: occupancy, ready, idle zeroing and in-order delivery.
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid_vs_occupancy", {63'd0, out_valid}, {63'd0, sb.size() != 0});
            if (armed) check("in_ready_vs_occupancy", {63'd0, in_ready}, {63'd0, sb.size() < 2});
            if (!out_valid) begin
                check("idle_fields_zero", {28'd0, out_instr, out_fmt, out_illegal}, 64'd0);
                check("idle_imm_zero", out_imm, 64'd0);
            end else if (out_ready && sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("pop_instr", {32'd0, out_instr}, {32'd0, mon_e.instr});
                check("pop_imm", out_imm, mon_e.imm);
                check("pop_fmt", {61'd0, out_fmt}, {61'd0, mon_e.fmt});
                check("pop_illegal", {63'd0, out_illegal}, {63'd0, mon_e.illegal});
            end
        end
    end

    // One clock of stimulus; entered and left at posedge+1.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
        in_valid = v;
        in_instr = ins;
        out_ready = ordy;
        flush = fl;
        @(negedge clk);
        #1;
        if (fl) sb.delete();
        else if (v && in_ready) sb.push_back(model(ins));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, with an instruction offered across the release edge.
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h00100093;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_instr", {32'd0, out_instr}, 64'd0);
        check("rst_out_imm", out_imm, 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("rel_in_ready_before_edge", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        check("rel_in_ready_after_edge", {63'd0, in_ready}, 64'd1);
        check("rel_no_early_accept", {63'd0, out_valid}, 64'd0);
        armed = 1'b1;
        in_valid = 1'b0;

        // Directed decode vectors, latency one cycle.
        cycle(1'b1, 32'hFFF00093, 1'b1, 1'b0);
        check("addi_valid", {63'd0, out_valid}, 64'd1);
        check("addi_fmt", {61'd0, out_fmt}, 64'd1);
        check("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
        check("beq_fmt", {61'd0, out_fmt}, 64'd3);
        check("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(1'b1, 32'h123452B7, 1'b1, 1'b0);
        check("lui_fmt", {61'd0, out_fmt}, 64'd4);
        check("lui_imm", out_imm, 64'h0000_0000_1234_5000);
        cycle(1'b1, 32'h03F09093, 1'b1, 1'b0);
        check("slli_fmt", {61'd0, out_fmt}, 64'd6);
        check("slli_imm", out_imm, 64'd63);
        cycle(1'b1, 32'h0000007F, 1'b1, 1'b0);
        check("illegal_flag", {63'd0, out_illegal}, 64'd1);
        check("illegal_fmt", {61'd0, out_fmt}, 64'd0);
        check("illegal_imm", out_imm, 64'd0);
        cycle(1'b1, 32'h00000013, 1'b1, 1'b0);
        check("legal_clears_illegal", {63'd0, out_illegal}, 64'd0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);

        // Back-pressure: A,B fill both slots, C waits upstream.
        cycle(1'b1, 32'h00A00513, 1'b0, 1'b0);
        cycle(1'b1, 32'h00B00593, 1'b0, 1'b0);
        check("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
        cycle(1'b1, 32'h00C00613, 1'b0, 1'b0);
        check("bp_held_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_head_is_a", {32'd0, out_instr}, 64'h00A00513);
        cycle(1'b1, 32'h00C00613, 1'b1, 1'b0);
        check("bp_second_is_b", {32'd0, out_instr}, 64'h00B00593);
        cycle(1'b1, 32'h00C00613, 1'b1, 1'b0);
        check("bp_third_is_c", {32'd0, out_instr}, 64'h00C00613);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        check("bp_drained", {63'd0, out_valid}, 64'd0);

        // Flush from TWO with a beat offered, then from ONE with accept+pop.
        cycle(1'b1, 32'h00100713, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200793, 1'b0, 1'b0);
        cycle(1'b1, 32'h00300813, 1'b0, 1'b1);
        check("flush_two_valid", {63'd0, out_valid}, 64'd0);
        check("flush_two_in_ready", {63'd0, in_ready}, 64'd1);
        cycle(1'b1, 32'h00400893, 1'b0, 1'b0);
        cycle(1'b1, 32'h00500913, 1'b1, 1'b1);
        check("flush_one_valid", {63'd0, out_valid}, 64'd0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        check("flush_one_stays_empty", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset while holding one entry.
        cycle(1'b1, 32'h00600993, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("async_rst_instr", {32'd0, out_instr}, 64'd0);
        sb.delete();
        armed = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("async_rel_in_ready_low", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        check("async_rel_in_ready_high", {63'd0, in_ready}, 64'd1);
        armed = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) < 60, rand_instr(),
                  $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 3);
        end

        // Bounded drain.
        for (int i = 0; i < 10 && (sb.size() != 0 || out_valid); i++) begin
            cycle(1'b0, 32'd0, 1'b1, 1'b0);
        end
        check("drain_scoreboard_empty", 64'(sb.size()), 64'd0);
        check("drain_out_valid", {63'd0, out_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
